// File: rtl/gdb_trigger_unit.sv
// Debug halt/step controller with address-match hardware breakpoints and watchpoints.
// Latency: trigger match or debug request in cycle t -> halt/evt/cause/hit_idx at t+1.
// Backpressure: none; halt is the stall request, matched transfers are never suppressed.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ifu_trn/ifu_adr        instruction fetch observed this cycle
//   lsu_trn/lsu_wen/lsu_adr load/store observed this cycle (wen=1 store)
//   dbg_hlt/res/stp        debugger halt / resume / single-step pulses
//   cfg_*                  trigger configuration write port
//   halt, evt, cause, hit_idx  halt request, HALTED-entry pulse, reason, trigger index
module gdb_trigger_unit #(
    parameter int   XLEN       = 32,
    parameter int   TRIG_N     = 4,
    parameter logic RESET_HALT = 1'b0,
    localparam int  IDXW       = (TRIG_N > 1) ? $clog2(TRIG_N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_trn,
    input  logic [XLEN-1:0] ifu_adr,
    input  logic            lsu_trn,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_adr,
    input  logic            dbg_hlt,
    input  logic            dbg_res,
    input  logic            dbg_stp,
    input  logic            cfg_wen,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [2:0]      cfg_typ,
    input  logic [XLEN-1:0] cfg_adr,
    input  logic [XLEN-1:0] cfg_msk,
    output logic            halt,
    output logic            evt,
    output logic [2:0]      cause,
    output logic [IDXW-1:0] hit_idx
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_REQ   = 3'd1;
    localparam logic [2:0] C_BREAK = 3'd2;
    localparam logic [2:0] C_WATCH = 3'd3;
    localparam logic [2:0] C_STEP  = 3'd4;

    // Trigger configuration; typ bits are {exec, load, store}.
    logic [2:0]      trg_typ [TRIG_N];
    logic [XLEN-1:0] trg_adr [TRIG_N];
    logic [XLEN-1:0] trg_msk [TRIG_N];

    state_t          state, state_nxt;
    logic [2:0]      cause_nxt;
    logic [IDXW-1:0] hit_idx_nxt;
    logic            evt_nxt;

    logic [TRIG_N-1:0] exe_hit, dat_hit;
    logic              exe_any, dat_any;
    logic [IDXW-1:0]   exe_idx, dat_idx;

    // Configuration writes. Matching the index against each slot means an
    // out-of-range cfg_idx simply selects nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TRIG_N; i++) begin
                trg_typ[i] <= '0;
                trg_adr[i] <= '0;
                trg_msk[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TRIG_N; i++) begin
                if (cfg_wen && (cfg_idx == IDXW'(i))) begin
                    trg_typ[i] <= cfg_typ;
                    trg_adr[i] <= cfg_adr;
                    trg_msk[i] <= cfg_msk;
                end
            end
        end
    end

    // Per-trigger address compare; msk bit 1 = bit participates.
    always_comb begin
        for (int i = 0; i < TRIG_N; i++) begin
            exe_hit[i] = trg_typ[i][2] & ifu_trn &
                         (((ifu_adr ^ trg_adr[i]) & trg_msk[i]) == '0);
            dat_hit[i] = lsu_trn &
                         ((trg_typ[i][1] & ~lsu_wen) | (trg_typ[i][0] & lsu_wen)) &
                         (((lsu_adr ^ trg_adr[i]) & trg_msk[i]) == '0);
        end
    end

    // Lowest index wins: scan downward so the last assignment is the lowest hit.
    always_comb begin
        exe_any = |exe_hit;
        dat_any = |dat_hit;
        exe_idx = '0;
        dat_idx = '0;
        for (int i = TRIG_N - 1; i >= 0; i--) begin
            if (exe_hit[i]) exe_idx = IDXW'(i);
            if (dat_hit[i]) dat_idx = IDXW'(i);
        end
    end

    // Next-state and halt-reason logic. cause/hit_idx hold unless a new
    // HALTED entry or a resume to RUN happens.
    always_comb begin
        state_nxt   = state;
        cause_nxt   = cause;
        hit_idx_nxt = hit_idx;
        case (state)
            ST_RUN: begin
                if (exe_any) begin
                    state_nxt   = ST_HALTED;
                    cause_nxt   = C_BREAK;
                    hit_idx_nxt = exe_idx;
                end else if (dat_any) begin
                    state_nxt   = ST_HALTED;
                    cause_nxt   = C_WATCH;
                    hit_idx_nxt = dat_idx;
                end else if (dbg_hlt) begin
                    state_nxt   = ST_HALTED;
                    cause_nxt   = C_REQ;
                    hit_idx_nxt = '0;
                end
            end
            ST_HALTED: begin
                if (dbg_stp) begin
                    state_nxt = ST_STEP;
                end else if (dbg_res) begin
                    state_nxt   = ST_RUN;
                    cause_nxt   = C_NONE;
                    hit_idx_nxt = '0;
                end
            end
            ST_STEP: begin
                // Exec triggers are ignored here so stepping off a breakpoint
                // does not immediately re-trigger on the same fetch.
                if (dat_any) begin
                    state_nxt   = ST_HALTED;
                    cause_nxt   = C_WATCH;
                    hit_idx_nxt = dat_idx;
                end else if (ifu_trn) begin
                    state_nxt   = ST_HALTED;
                    cause_nxt   = C_STEP;
                    hit_idx_nxt = '0;
                end else if (dbg_hlt) begin
                    state_nxt   = ST_HALTED;
                    cause_nxt   = C_REQ;
                    hit_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_RUN;
                cause_nxt   = C_NONE;
                hit_idx_nxt = '0;
            end
        endcase
        evt_nxt = (state_nxt == ST_HALTED) && (state != ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET_HALT ? ST_HALTED : ST_RUN;
            cause   <= RESET_HALT ? C_REQ : C_NONE;
            hit_idx <= '0;
            evt     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause   <= cause_nxt;
            hit_idx <= hit_idx_nxt;
            evt     <= evt_nxt;
        end
    end

    assign halt = (state == ST_HALTED);

endmodule
